// File: rtl/spike_time_encoder.sv
// Spike-time encoder: turns a binary spike time into one pulse inside a gamma cycle and
// generates the per-gamma reset strobe for the downstream temporal comparators.
// Values enter through a one-deep valid/ready holding buffer and are emitted the next gamma.
// Optional build macro SPIKE_ENCODER_HOLD_EN: with nothing pending at a gamma boundary the
// previous spike time is kept, so the last accepted spike repeats every gamma.
module spike_time_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] in_time,
  output logic          q,
  output logic          gamma_rst,
  output logic [TW-1:0] gamma_cnt
);

  // Last slot of a gamma; as a spike time it also means "no spike".
  localparam logic [TW-1:0] TMax = TW'(GAMMA_CYCLE_WIDTH - 1);
  // Pulses are truncated at slot G-1 anyway, so clamping PW keeps cur_t+1+PW inside TW+1 bits.
  localparam int PwEff = (PULSE_WIDTH < GAMMA_CYCLE_WIDTH - 1) ? PULSE_WIDTH
                                                                : GAMMA_CYCLE_WIDTH - 1;

  logic [TW-1:0] g_cnt_q, g_cnt_d;
  logic [TW-1:0] cur_t_q, cur_t_d;
  logic [TW-1:0] pend_t_q, pend_t_d;
  logic          pend_full_q, pend_full_d;

  logic          boundary;
  logic          accept;
  logic [TW:0]   pulse_lo;
  logic [TW:0]   pulse_hi;
  logic [TW:0]   slot_ext;

  assign boundary = (g_cnt_q == TMax);
  assign accept   = in_valid & ~pend_full_q;

  // Next-state: free-running gamma counter, boundary hand-over, buffer fill on accept.
  always_comb begin
    g_cnt_d     = boundary ? '0 : g_cnt_q + TW'(1);
    cur_t_d     = cur_t_q;
    pend_t_d    = pend_t_q;
    pend_full_d = pend_full_q;

    if (boundary) begin
      if (pend_full_q) begin
        cur_t_d     = pend_t_q;
        pend_full_d = 1'b0;
      end else begin
`ifdef SPIKE_ENCODER_HOLD_EN
        cur_t_d = cur_t_q;
`else
        cur_t_d = TMax;
`endif
      end
    end

    // Accept only happens with the buffer empty, so it never collides with the hand-over above.
    if (accept) begin
      pend_t_d    = in_time;
      pend_full_d = 1'b1;
    end
  end

  // State registers; reset forces "no spike" so an active pulse drops immediately.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      g_cnt_q     <= '0;
      cur_t_q     <= TMax;
      pend_t_q    <= '0;
      pend_full_q <= 1'b0;
    end else begin
      g_cnt_q     <= g_cnt_d;
      cur_t_q     <= cur_t_d;
      pend_t_q    <= pend_t_d;
      pend_full_q <= pend_full_d;
    end
  end

  // Outputs decoded from registered state only; the window starts at cur_t+1 to keep slot 0 free.
  always_comb begin
    slot_ext  = {1'b0, g_cnt_q};
    pulse_lo  = {1'b0, cur_t_q} + (TW+1)'(1);
    pulse_hi  = pulse_lo + (TW+1)'(PwEff);
    q         = (cur_t_q < TMax) && (slot_ext >= pulse_lo) && (slot_ext < pulse_hi);
    gamma_rst = (g_cnt_q == '0);
    gamma_cnt = g_cnt_q;
    in_ready  = ~pend_full_q;
  end

endmodule

// File: tb/tb_spike_time_encoder.sv
// Directed bench for spike_time_encoder (G=16, PW=8) with a scoreboard of expected outputs.
module tb_spike_time_encoder;

  localparam int G  = 16;
  localparam int PW = 8;
  localparam int TW = 4;

  typedef struct packed {
    logic          q;
    logic          gr;
    logic [TW-1:0] cnt;
    logic          rdy;
  } obs_t;

  logic          aclk = 1'b0;
  logic          grst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_time = '0;
  logic          q;
  logic          gamma_rst;
  logic [TW-1:0] gamma_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t sb[$];

  spike_time_encoder #(
    .GAMMA_CYCLE_WIDTH(G),
    .PULSE_WIDTH      (PW)
  ) dut (
    .aclk     (aclk),
    .grst     (grst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_time  (in_time),
    .q        (q),
    .gamma_rst(gamma_rst),
    .gamma_cnt(gamma_cnt)
  );

  always #5 aclk = ~aclk;

  // Spike time expected in the gamma after one with nothing pending at its boundary.
  function automatic int nt(input int prev);
`ifdef SPIKE_ENCODER_HOLD_EN
    return prev;
`else
    return G - 1;
`endif
  endfunction

  function automatic logic exp_q(input int t, input int s);
    return (t < G - 1) && (s >= t + 1) && (s <= t + PW) && (s <= G - 1);
  endfunction

  function automatic obs_t mk(input logic eq, input int s, input logic erdy);
    obs_t e;
    e.q   = eq;
    e.gr  = (s == 0);
    e.cnt = TW'(s);
    e.rdy = erdy;
    return e;
  endfunction

  task automatic check_now(input string tag);
    obs_t a;
    obs_t e;
    a = {q, gamma_rst, gamma_cnt, in_ready};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got %b", tag, a);
    end else begin
      e = sb.pop_front();
      assert (a === e) else begin
        n_fail++;
        $error("FAIL %s: got q=%b rst=%b cnt=%0d rdy=%b, want q=%b rst=%b cnt=%0d rdy=%b",
               tag, a.q, a.gr, a.cnt, a.rdy, e.q, e.gr, e.cnt, e.rdy);
      end
    end
  endtask

  // Runs n slots of one gamma starting at slot 0: pulse time t, in_ready low on
  // slots lo_from..lo_to, in_valid on slots v_from..v_to (va on the first, vb after).
  task automatic gamma(input string tag, input int t, input int lo_from, input int lo_to,
                       input int v_from, input int v_to, input int va, input int vb,
                       input int n);
    for (int s = 0; s < n; s++)
      sb.push_back(mk(exp_q(t, s), s, !(s >= lo_from && s <= lo_to)));
    for (int s = 0; s < n; s++) begin
      check_now($sformatf("%s s%0d", tag, s));
      in_valid = (s >= v_from && s <= v_to);
      in_time  = TW'((s == v_from) ? va : vb);
      @(posedge aclk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state while grst is held, then release between edges.
    #2;
    sb.push_back(mk(1'b0, 0, 1'b1));
    check_now("reset");
    #21;
    grst = 1'b0;

    // Idle: four quiet gammas.
    for (int i = 0; i < 4; i++) gamma($sformatf("idle%0d", i), G - 1, 99, -1, 99, -1, 0, 0, G);

    // Nominal: 3 accepted at slot 5, pulse 4..11 next gamma.
    gamma("nom_acc", G - 1, 6, 15, 5, 5, 3, 3, G);
    gamma("nom_pulse", 3, 99, -1, 99, -1, 0, 0, G);

    // Truncation: 12 -> slots 13..15 only; then a no-spike value 15.
    gamma("trunc_acc", nt(3), 6, 15, 5, 5, 12, 12, G);
    gamma("trunc_pulse", 12, 6, 15, 5, 5, 15, 15, G);
    gamma("nospike", 15, 99, -1, 99, -1, 0, 0, G);

    // Backpressure: 2 at slot 3, then 5 held until accepted at slot 0 of the next gamma.
    gamma("bp_acc", nt(15), 4, 15, 3, 15, 2, 5, G);
    gamma("bp_p2", 2, 1, 15, 0, 0, 5, 5, G);

    // Boundary accept: 9 offered at slot 15 lands two gammas later.
    gamma("bnd_p5", 5, 99, -1, 15, 15, 9, 9, G);
    gamma("bnd_wait", nt(5), 0, 15, 99, -1, 0, 0, G);
    gamma("bnd_p9", 9, 99, -1, 99, -1, 0, 0, G);

    // Reset mid-pulse with a value pending: both must vanish.
    gamma("rst_acc", nt(9), 6, 15, 5, 5, 3, 3, G);
    gamma("rst_pre", 3, 3, 15, 2, 2, 7, 7, 6);
    sb.push_back(mk(1'b1, 6, 1'b0));
    check_now("rst_pulse_on");
    grst = 1'b1;
    #1;
    sb.push_back(mk(1'b0, 0, 1'b1));
    check_now("rst_async");
    #1;
    grst = 1'b0;
    #1;
    gamma("rst_post0", G - 1, 99, -1, 99, -1, 0, 0, G);
    gamma("rst_post1", G - 1, 99, -1, 99, -1, 0, 0, G);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
